// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Results are computed from operands latched at acceptance and committed on the final busy edge.
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             req,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out,
    output logic             div_zero
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    localparam logic [3:0] OP_MTHI = 4'd8;
    localparam logic [3:0] OP_MTLO = 4'd9;
    localparam logic [3:0] OP_MFHI = 4'd10;
    localparam logic [3:0] OP_MFLO = 4'd11;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] rs_q, rt_q, hi_q, lo_q;
    logic             div_zero_q, dz_save_q;

    logic             accept, is_mul, is_div, run_div, signed_op;
    logic [2*WIDTH-1:0] a_ext, b_ext, product, acc;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag, divisor, q_mag, r_mag, quot, rem;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign busy     = (state_q == S_RUN);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

    assign accept = start && (state_q == S_IDLE) && !req;
    assign is_div = (op[3:1] == 3'b001);
    assign is_mul = !op[3] && !is_div;

    // Codes 0..7 alternate signed/unsigned, so bit 0 selects signedness for every run op.
    assign run_div   = (op_q[2:1] == 2'b01);
    assign signed_op = !op_q[0];

    assign a_ext   = {{WIDTH{signed_op & rs_q[WIDTH-1]}}, rs_q};
    assign b_ext   = {{WIDTH{signed_op & rt_q[WIDTH-1]}}, rt_q};
    assign product = a_ext * b_ext;
    assign acc     = {hi_q, lo_q};

    // Sign-magnitude division; a zero divisor is replaced by 1 so the divider never sees it.
    assign rs_neg  = signed_op & rs_q[WIDTH-1];
    assign rt_neg  = signed_op & rt_q[WIDTH-1];
    assign rs_mag  = rs_neg ? -rs_q : rs_q;
    assign rt_mag  = rt_neg ? -rt_q : rt_q;
    assign divisor = (rt_q == '0) ? WIDTH'(1) : rt_mag;
    assign q_mag   = rs_mag / divisor;
    assign r_mag   = rs_mag % divisor;
    assign quot    = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
    assign rem     = rs_neg ? -r_mag : r_mag;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            3'd0, 3'd1: {res_hi, res_lo} = product;
            3'd2, 3'd3: begin
                res_hi = rem;
                res_lo = quot;
            end
            3'd4, 3'd5: {res_hi, res_lo} = acc + product;
            default:    {res_hi, res_lo} = acc - product;
        endcase
    end

    always_comb begin
        md_out = '0;
        if (op == OP_MFHI) md_out = hi_q;
        else if (op == OP_MFLO) md_out = lo_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
            dz_save_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul || is_div) begin
                            state_q   <= S_RUN;
                            op_q      <= op[2:0];
                            rs_q      <= rs;
                            rt_q      <= rt;
                            cnt_q     <= is_div ? DIV_CNT : MUL_CNT;
                            dz_save_q <= div_zero_q;
                            if (is_div && (rt != '0)) div_zero_q <= 1'b0;
                        end else if (op == OP_MTHI) begin
                            hi_q <= rs;
                        end else if (op == OP_MTLO) begin
                            lo_q <= rs;
                        end
                    end
                end
                default: begin
                    if (req) begin
                        // Abort restores the flag as it stood before this operation began.
                        state_q    <= S_IDLE;
                        cnt_q      <= '0;
                        div_zero_q <= dz_save_q;
                    end else if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        if (run_div && (rt_q == '0)) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
